nonce_search_ctrl: RTL and testbench
====================================

Name: nonce_search_ctrl

Overview:
- Sequences the nonce search around the 128-bit block concatenator and the downstream hash core.
- For each candidate nonce it drives the concatenator selector and nonce, then issues a hash request and waits for the result.
- Compares the hash against the target and either stops on a hit or advances the nonce.
- Reports a golden nonce, or exhaustion of the search range, to the top-level host logic.

Parameters:
NONCE_W, 32, nonce width; matches concatenator nonce input
HASH_W, 24, width of hash result compared against target
MAX_NONCE, 32'hFFFF_FFFF, last nonce tried (inclusive)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins search at nonce_base; ignored unless idle
abort  input  1  level; stops search at next state evaluation
nonce_base  input  NONCE_W  first nonce of search, sampled on accepted start
target  input  HASH_W  threshold, sampled on accepted start; hit when hash_out < target
selector  output  1  concatenator enable
nonce  output  NONCE_W  current candidate to concatenator
hash_start  output  1  one-cycle request to hash core
hash_done  input  1  one-cycle pulse from hash core, hash_out valid
hash_out  input  HASH_W  hash result
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse, search finished
found  output  1  level; valid from done until next accepted start
golden_nonce  output  NONCE_W  nonce producing hit; held until next accepted start

Behaviour:
- Reset (async, reset=0): state IDLE; selector, hash_start, busy, done, found = 0; nonce, golden_nonce, target register = 0.
- IDLE: start=1 captures nonce_base into nonce and target into target register, clears found, goes to LOAD; busy=1 from next cycle.
- LOAD (1 cycle): selector=1, giving the concatenator its one register stage. Goes to REQ.
- REQ (1 cycle): selector=1, hash_start=1. Goes to WAIT.
- WAIT: selector=1 while waiting for hash_done, with no timeout.
  - hash_done=1 and hash_out < target (unsigned): golden_nonce<=nonce, found<=1, go to FIN.
  - hash_done=1, no hit, nonce==MAX_NONCE: found<=0, go to FIN.
  - hash_done=1, no hit otherwise: nonce<=nonce+1, go to LOAD.
- FIN (1 cycle): done=1, busy=0 on exit, selector=0, go to IDLE.
- Latency: start to first hash_start = 3 cycles (IDLE->LOAD->REQ). Per-nonce overhead is 2 cycles plus hash core latency.
- abort=1 in LOAD, REQ or WAIT: go to FIN with found=0; any later hash_done is ignored. In WAIT, abort takes priority over a simultaneous hash_done.
- hash_done outside WAIT: ignored.
- start while busy: ignored, with no effect on nonce or target.
- No wrap-around: nonce never increments past MAX_NONCE. If nonce_base > MAX_NONCE, exactly one nonce (nonce_base) is tried, then the search ends.
- Hit check uses strict less-than. hash_out == target is not a hit; target=0 never hits.
- reset deasserted mid-search: everything clears asynchronously; nothing resumes afterwards.
- selector=0 in IDLE and FIN, so the concatenator outputs a zero block while the controller is idle.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=3'd0, LOAD=3'd1, REQ=3'd2, WAIT=3'd3, FIN=3'd4
  - NONCE_W, HASH_W defaults
- No sub-module: a single FSM plus nonce counter and comparator.
- The top level instantiates this block next to the concatenator, with selector and nonce wired directly.

Test Plan:
- Reset mid-WAIT (nonce=0x10) -> all outputs 0 immediately; after release, IDLE with no hash_start.
- start, nonce_base=0x100, target=0x000800; hash model returns 0x001000 for 0x100 and 0x101, and 0x0007FF for 0x102 -> three hash_start pulses; done with found=1, golden_nonce=0x102; busy low after done.
- Exhaustion: MAX_NONCE=0x0000_0003, nonce_base=0x1, target=0 -> exactly 3 hash_start pulses (nonces 1,2,3); done with found=0; nonce stays 0x3.
- Boundary compare: hash_out == target (0x000800) -> no hit, nonce increments; then 0x0007FF -> hit.
- abort raised in the same cycle as hash_done with a hitting hash -> FIN with found=0; golden_nonce unchanged; done pulses once.
- start re-pulsed while busy, plus spurious hash_done in LOAD -> both ignored; nonce sequence and hash_start count unchanged; start to first hash_start = 3 cycles.

Source files
------------

// File: rtl/nonce_search_ctrl_pkg.sv
// Shared definitions for the nonce search controller: FSM encoding and default widths.
package nonce_search_ctrl_pkg;

   localparam int unsigned NONCE_W_DEF = 32;
   localparam int unsigned HASH_W_DEF  = 24;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      REQ  = 3'd2,
      WAIT = 3'd3,
      FIN  = 3'd4
   } state_e;

endpackage

// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: walks candidate nonces through the block concatenator and
// hash core, stopping on the first hash below target, on exhaustion, or on abort.
module nonce_search_ctrl
   import nonce_search_ctrl_pkg::*;
#(
   parameter int unsigned        NONCE_W   = NONCE_W_DEF,
   parameter int unsigned        HASH_W    = HASH_W_DEF,
   parameter logic [NONCE_W-1:0] MAX_NONCE = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [NONCE_W-1:0] nonce_base,
   input  logic [HASH_W-1:0]  target,
   output logic               selector,
   output logic [NONCE_W-1:0] nonce,
   output logic               hash_start,
   input  logic               hash_done,
   input  logic [HASH_W-1:0]  hash_out,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] golden_nonce
);

   state_e            state_q, state_d;
   logic [HASH_W-1:0] target_q;
   logic              accept;
   logic              take_hit;
   logic              advance;
   logic              hit;
   logic              last;

   assign hit  = (hash_out < target_q);
   // >= rather than == so a base above MAX_NONCE still ends after one try
   assign last = (nonce >= MAX_NONCE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      selector   = 1'b0;
      hash_start = 1'b0;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      accept     = 1'b0;
      take_hit   = 1'b0;
      advance    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            selector = 1'b1;
            state_d  = abort ? FIN : REQ;
         end
         REQ: begin
            selector   = 1'b1;
            hash_start = 1'b1;
            state_d    = abort ? FIN : WAIT;
         end
         WAIT: begin
            selector = 1'b1;
            if (abort) begin
               state_d = FIN;
            end else if (hash_done) begin
               if (hit) begin
                  take_hit = 1'b1;
                  state_d  = FIN;
               end else if (last) begin
                  state_d = FIN;
               end else begin
                  advance = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nonce        <= '0;
         golden_nonce <= '0;
         target_q     <= '0;
         found        <= 1'b0;
      end else begin
         if (accept) begin
            nonce    <= nonce_base;
            target_q <= target;
            found    <= 1'b0;
         end
         if (take_hit) begin
            golden_nonce <= nonce;
            found        <= 1'b1;
         end
         if (advance) begin
            nonce <= nonce + NONCE_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Randomized and directed bench for nonce_search_ctrl against a search-level reference model.
module tb_nonce_search_ctrl;

   localparam int unsigned NW   = 32;
   localparam int unsigned HW   = 24;
   localparam logic [31:0] MAXN = 32'h0000_0103;

   logic          clk = 1'b0;
   logic          reset, start, abort, abort_m, abort_r;
   logic [NW-1:0] nonce_base, nonce, golden_nonce;
   logic [HW-1:0] target, hash_out;
   logic          selector, hash_start, hash_done, busy, done, found;

   always #5 clk = ~clk;

   assign abort = abort_m | abort_r;

   nonce_search_ctrl #(.NONCE_W(NW), .HASH_W(HW), .MAX_NONCE(MAXN)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .nonce_base(nonce_base), .target(target), .selector(selector), .nonce(nonce),
      .hash_start(hash_start), .hash_done(hash_done), .hash_out(hash_out),
      .busy(busy), .done(done), .found(found), .golden_nonce(golden_nonce)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a search is active, in its finish cycle, or some number of
   // cycles into the current nonce (0 = loading, 1 = requesting, 2+ = awaiting result).
   bit          m_busy, m_fin, m_found;
   int          m_step;
   logic [31:0] m_nonce, m_golden;
   logic [23:0] m_target;

   function automatic void model_step();
      if (!reset) begin
         m_busy = 0; m_fin = 0; m_found = 0; m_step = 0;
         m_nonce = '0; m_golden = '0; m_target = '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_fin = 0; m_step = 0; m_found = 0;
            m_nonce = nonce_base; m_target = target;
         end
      end else if (m_fin) begin
         m_busy = 0; m_fin = 0;
      end else if (abort) begin
         m_fin = 1;
      end else if (m_step < 2) begin
         m_step++;
      end else if (hash_done) begin
         if (hash_out < m_target) begin
            m_golden = m_nonce; m_found = 1; m_fin = 1;
         end else if (m_nonce >= MAXN) begin
            m_fin = 1;
         end else begin
            m_nonce = m_nonce + 1; m_step = 0;
         end
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("cyc_selector",   selector,     m_busy && !m_fin);
         chk("cyc_hash_start", hash_start,   m_busy && !m_fin && m_step == 1);
         chk("cyc_busy",       busy,         m_busy);
         chk("cyc_done",       done,         m_fin);
         chk("cyc_found",      found,        m_found);
         chk("cyc_nonce",      nonce,        m_nonce);
         chk("cyc_golden",     golden_nonce, m_golden);
      end
   end

   // Hash core stand-in: answers each hash_start after a latency with a mode-selected hash.
   int          mode = 0;
   int          lat_cfg = 0;
   int          hs_count = 0;
   bit          abort_on_done = 0;
   bit          spur_arm = 0;

   function automatic logic [23:0] hash_of(input logic [31:0] n);
      case (mode)
         1:       return (n == 32'h102) ? 24'h0007FF : 24'h001000;
         2:       return (n == 32'h100) ? 24'h000800 : 24'h0007FF;
         3:       return 24'hFFFFFF;
         default: return 24'($urandom_range(0, 32'h00FF_FFFF));
      endcase
   endfunction

   initial begin
      int          cd;
      bit          spur_next;
      logic [31:0] req_nonce;
      hash_done = 0; abort_r = 0; hash_out = '0; cd = 0; spur_next = 0; req_nonce = '0;
      forever begin
         @(negedge clk);
         hash_done = 0;
         abort_r   = 0;
         if (!reset) begin
            cd = 0; spur_next = 0;
         end else begin
            if (spur_next) begin
               hash_done = 1; hash_out = '0; spur_next = 0;
            end
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  hash_done = 1;
                  hash_out  = hash_of(req_nonce);
                  if (abort_on_done) begin abort_r = 1; abort_on_done = 0; end
                  if (spur_arm) begin spur_next = 1; spur_arm = 0; end
               end
            end
            if (hash_start) begin
               hs_count++;
               req_nonce = nonce;
               cd = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] b, input logic [23:0] t);
      hs_count = 0;
      @(negedge clk); start = 1; nonce_base = b; target = t;
      @(negedge clk); start = 0;
   endtask

   task automatic wait_done(output int dn);
      bit seen;
      dn = 0; seen = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (done) begin dn++; seen = 1; end
         if (seen && !busy) break;
      end
      chk("search_finished", seen, 1);
      repeat (3) begin @(negedge clk); if (done) dn++; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn, lat;
      bit seen;
      logic [31:0] b;
      reset = 0; start = 0; abort_m = 0; nonce_base = '0; target = '0;
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_selector", selector, 0);
      chk("rst_nonce", nonce, 0);
      chk("rst_golden", golden_nonce, 0);
      chk("rst_found", found, 0);

      // reset asserted while waiting on the hash for nonce 0x10
      mode = 3; lat_cfg = 20;
      pulse_start(32'h10, 24'h0);
      for (int k = 0; k < 10 && hs_count == 0; k++) @(negedge clk);
      @(negedge clk); @(negedge clk);
      chk("pre_rst_nonce", nonce, 32'h10);
      chk("pre_rst_selector", selector, 1);
      #2 reset = 0;
      #1;
      chk("midrst_selector", selector, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_hash_start", hash_start, 0);
      chk("midrst_nonce", nonce, 0);
      chk("midrst_found", found, 0);
      @(negedge clk); @(negedge clk);
      reset = 1;
      hs_count = 0;
      repeat (8) @(negedge clk);
      chk("post_rst_no_hs", hs_count, 0);
      chk("post_rst_busy", busy, 0);

      // hit on third nonce, with start re-pulsed and a spurious hash_done in LOAD
      mode = 1; lat_cfg = 3; spur_arm = 1; hs_count = 0;
      @(negedge clk); start = 1; nonce_base = 32'h100; target = 24'h000800; lat = 1;
      @(negedge clk); start = 0; lat = 2;
      for (int k = 0; k < 10 && !hash_start; k++) begin @(negedge clk); lat++; end
      chk("start_to_hs_cycles", lat, 3);
      @(negedge clk); start = 1; nonce_base = 32'h5555; target = 24'hFFFFFF;
      @(negedge clk); start = 0;
      wait_done(dn);
      chk("hit_done_pulses", dn, 1);
      chk("hit_hs_count", hs_count, 3);
      chk("hit_found", found, 1);
      chk("hit_golden", golden_nonce, 32'h102);
      chk("hit_busy_after", busy, 0);

      // hash equal to target is not a hit
      mode = 2; lat_cfg = 2;
      pulse_start(32'h100, 24'h000800);
      wait_done(dn);
      chk("eq_hs_count", hs_count, 2);
      chk("eq_golden", golden_nonce, 32'h101);
      chk("eq_found", found, 1);

      // exhaustion up to MAX_NONCE with an unreachable target
      mode = 3; lat_cfg = 0;
      pulse_start(32'h101, 24'h0);
      wait_done(dn);
      chk("exh_hs_count", hs_count, 3);
      chk("exh_found", found, 0);
      chk("exh_nonce", nonce, 32'h103);
      chk("exh_golden_kept", golden_nonce, 32'h101);

      // base above MAX_NONCE: exactly one try
      pulse_start(32'h200, 24'h0);
      wait_done(dn);
      chk("over_hs_count", hs_count, 1);
      chk("over_nonce", nonce, 32'h200);
      chk("over_found", found, 0);

      // abort coincident with a hitting hash_done
      mode = 1; lat_cfg = 2; abort_on_done = 1;
      pulse_start(32'h102, 24'h000800);
      wait_done(dn);
      chk("abort_done_pulses", dn, 1);
      chk("abort_found", found, 0);
      chk("abort_golden_kept", golden_nonce, 32'h101);
      chk("abort_hs_count", hs_count, 1);

      // randomized searches with random aborts and ignored starts
      mode = 0; lat_cfg = 0;
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 9) < 7) b = MAXN - $urandom_range(0, 6);
         else b = 32'h8000_0000 | $urandom;
         pulse_start(b, 24'($urandom_range(0, 32'h0020_0000)));
         seen = 0;
         for (int k = 0; k < 500; k++) begin
            abort_m = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) begin
               start = 1; nonce_base = $urandom; target = 24'($urandom);
            end else begin
               start = 0;
            end
            @(negedge clk);
            if (done) seen = 1;
            if (seen && !busy) break;
         end
         abort_m = 0; start = 0;
         chk("rand_finished", seen, 1);
         repeat (6) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
